// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: steers MIDI note-on / note-off / all-notes-off messages
// to a parallel bank of NUM_VOICES voices, tracking which voice owns which note.
// Build option: define VOICE_RR_EN for round-robin note-on allocation
// (scan starts after the last allocated voice); otherwise lowest index first.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [23:0]           MIDI_MSG,
  input  logic                  MIDI_MSG_RDY,
  output logic                  MIDI_BUSY,
  output logic                  OVERRUN,
  input  logic [NUM_VOICES-1:0] VOICE_ACTIVE,
  output logic [23:0]           VOICE_MSG,
  output logic [NUM_VOICES-1:0] VOICE_MSG_RDY,
  output logic                  DROP
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;
  typedef enum logic [1:0] {C_NONE, C_ON, C_OFF, C_ALL} cls_t;

  localparam logic [VIDX_W-1:0] LAST = VIDX_W'(NUM_VOICES - 1);
  localparam logic [NUM_VOICES-1:0] ONE = NUM_VOICES'(1);

  state_t                     state;
  cls_t                       cls, in_cls;
  logic [23:0]                msg;
  logic [NUM_VOICES-1:0]      alloc;
  logic [NUM_VOICES-1:0][7:0] note;
  logic [VIDX_W-1:0]          idx, cnt, hit_idx, last_alloc, on_start, fin_idx;
  logic                       hit_found, cur_hit, fin_found;

  // Decode the incoming message; only channel-0 status bytes are recognised.
  always_comb begin
    in_cls = C_NONE;
    if (MIDI_MSG[23:16] == 8'h90 && MIDI_MSG[7:0] != 8'h00)
      in_cls = C_ON;
    else if (MIDI_MSG[23:16] == 8'h80 || MIDI_MSG[23:16] == 8'h90)
      in_cls = C_OFF;
    else if (MIDI_MSG[23:16] == 8'hB0 && MIDI_MSG[15:8] == 8'h7B)
      in_cls = C_ALL;
  end

`ifdef VOICE_RR_EN
  // Start just past the last allocated voice so releasing voices get time to finish.
  assign on_start = (last_alloc == LAST) ? '0 : last_alloc + 1'b1;
`else
  // Lowest-index-first; last_alloc is still tracked but not consulted.
  logic rr_unused;
  assign on_start  = '0;
  assign rr_unused = ^last_alloc;
`endif

  // Hit test for the voice visited this cycle, plus the final result on the last visit.
  always_comb begin
    if (cls == C_ON) cur_hit = !alloc[idx] && !VOICE_ACTIVE[idx];
    else             cur_hit = alloc[idx] && (note[idx] == msg[15:8]);
    fin_found = hit_found || cur_hit;
    fin_idx   = hit_found ? hit_idx : idx;
  end

  // Control FSM with registered outputs; ownership table updates on issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cls           <= C_NONE;
      msg           <= '0;
      alloc         <= '0;
      note          <= '0;
      idx           <= '0;
      cnt           <= '0;
      hit_idx       <= '0;
      hit_found     <= 1'b0;
      last_alloc    <= LAST;
      MIDI_BUSY     <= 1'b0;
      OVERRUN       <= 1'b0;
      VOICE_MSG     <= '0;
      VOICE_MSG_RDY <= '0;
      DROP          <= 1'b0;
    end else begin
      VOICE_MSG_RDY <= '0;
      DROP          <= 1'b0;
      // Anything arriving while not idle is discarded and flagged.
      OVERRUN       <= MIDI_MSG_RDY && (state != IDLE);
      case (state)
        IDLE: begin
          if (MIDI_MSG_RDY) begin
            msg       <= MIDI_MSG;
            cls       <= in_cls;
            cnt       <= '0;
            hit_found <= 1'b0;
            case (in_cls)
              C_ON: begin
                idx       <= on_start;
                state     <= SCAN;
                MIDI_BUSY <= 1'b1;
              end
              C_OFF: begin
                idx       <= '0;
                state     <= SCAN;
                MIDI_BUSY <= 1'b1;
              end
              C_ALL: begin
                state         <= ISSUE;
                MIDI_BUSY     <= 1'b1;
                VOICE_MSG     <= MIDI_MSG;
                VOICE_MSG_RDY <= '1;
                alloc         <= '0;
              end
              default: ;
            endcase
          end
        end
        SCAN: begin
          if (cur_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
          cnt <= cnt + 1'b1;
          // Fixed-length scan: resolve on the final visit so the issue is registered.
          if (cnt == LAST) begin
            state     <= ISSUE;
            VOICE_MSG <= msg;
            if (cls == C_ON) begin
              if (fin_found) begin
                VOICE_MSG_RDY  <= ONE << fin_idx;
                alloc[fin_idx] <= 1'b1;
                note[fin_idx]  <= msg[15:8];
                last_alloc     <= fin_idx;
              end else begin
                DROP <= 1'b1;
              end
            end else if (fin_found) begin
              VOICE_MSG_RDY  <= ONE << fin_idx;
              alloc[fin_idx] <= 1'b0;
            end
          end
        end
        ISSUE: begin
          state     <= IDLE;
          MIDI_BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: a voice-ownership model predicts each
// issue (strobe, drop, message, cycle) and each overrun; a monitor compares.
module tb_midi_voice_alloc;
  localparam int N   = 4;
  localparam int LAT = N + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [23:0]   MIDI_MSG = '0;
  logic          MIDI_MSG_RDY = 1'b0;
  logic          MIDI_BUSY, OVERRUN, DROP;
  logic [N-1:0]  VOICE_ACTIVE = '0;
  logic [23:0]   VOICE_MSG;
  logic [N-1:0]  VOICE_MSG_RDY;

  midi_voice_alloc #(.NUM_VOICES(N), .VIDX_W(2)) dut (
    .CLK(CLK), .RST(RST), .MIDI_MSG(MIDI_MSG), .MIDI_MSG_RDY(MIDI_MSG_RDY),
    .MIDI_BUSY(MIDI_BUSY), .OVERRUN(OVERRUN), .VOICE_ACTIVE(VOICE_ACTIVE),
    .VOICE_MSG(VOICE_MSG), .VOICE_MSG_RDY(VOICE_MSG_RDY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [N-1:0] rdy;
    logic         drop;
    logic [23:0]  msg;
  } exp_t;

  exp_t        sq[$];
  int          oq[$];
  exp_t        me;
  int          mo;
  int          vectors = 0, miscompares = 0;
  int          bstart = 1, bend = 0;
  bit          mon_en = 1'b0;

  // reference model state
  bit          own[N];
  logic [7:0]  onote[N];
  bit          act[N];
  int          last = N - 1;
  int          pend = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic int find_on();
    int s;
`ifdef VOICE_RR_EN
    s = (last + 1) % N;
`else
    s = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int v;
      v = (s + k) % N;
      if (!own[v] && !act[v]) return v;
    end
    return -1;
  endfunction

  function automatic int find_off(input logic [7:0] n);
    for (int v = 0; v < N; v++)
      if (own[v] && onote[v] == n) return v;
    return -1;
  endfunction

  function automatic logic [23:0] rand_msg();
    int r;
    logic [7:0] n;
    r = $urandom_range(0, 99);
    n = 8'h3C + 8'($urandom_range(0, 5));
    if (r < 45)      return {8'h90, n, 8'($urandom_range(1, 127))};
    else if (r < 62) return {8'h80, n, 8'($urandom_range(0, 127))};
    else if (r < 77) return {8'h90, n, 8'h00};
    else if (r < 83) return {8'hB0, 8'h7B, 8'h00};
    else if (r < 88) return {8'hC0, n, 8'h00};
    else if (r < 93) return {8'h91, n, 8'h40};
    else if (r < 97) return {8'hB0, 8'h7A, 8'h00};
    else             return {8'h81, n, 8'h00};
  endfunction

  // Present one message; the model decides what the voices must see and when.
  task automatic send(input logic [23:0] m);
    int c, v;
    exp_t e;
    logic [7:0] st, d1, d2;
    st = m[23:16]; d1 = m[15:8]; d2 = m[7:0];
    pend = -1;
    for (int i = 0; i < N; i++) VOICE_ACTIVE[i] = act[i];
    c = cyc;
    MIDI_MSG = m;
    MIDI_MSG_RDY = 1'b1;
    e.msg = m; e.drop = 1'b0; e.rdy = '0; e.due = c + LAT;
    if (st == 8'h90 && d2 != 8'h00) begin
      v = find_on();
      if (v < 0) e.drop = 1'b1;
      else begin
        e.rdy[v] = 1'b1; own[v] = 1'b1; onote[v] = d1; last = v; pend = v;
      end
      sq.push_back(e);
      bstart = c + 1; bend = c + LAT;
    end else if (st == 8'h80 || st == 8'h90) begin
      v = find_off(d1);
      if (v >= 0) begin
        e.rdy[v] = 1'b1; own[v] = 1'b0;
        sq.push_back(e);
      end
      bstart = c + 1; bend = c + LAT;
    end else if (st == 8'hB0 && d1 == 8'h7B) begin
      e.due = c + 1; e.rdy = '1;
      for (int i = 0; i < N; i++) own[i] = 1'b0;
      sq.push_back(e);
      bstart = c + 1; bend = c + 1;
    end
    @(posedge CLK); #1;
    MIDI_MSG_RDY = 1'b0;
  endtask

  // A message offered while busy must be dropped and flagged next cycle.
  task automatic inject();
    MIDI_MSG = rand_msg();
    MIDI_MSG_RDY = 1'b1;
    oq.push_back(cyc + 1);
    @(posedge CLK); #1;
    MIDI_MSG_RDY = 1'b0;
  endtask

  // Wait until the allocator is idle again; an allocated voice then starts sounding.
  task automatic wait_idle();
    while (cyc <= bend) begin @(posedge CLK); #1; end
    if (pend >= 0) act[pend] = 1'b1;
    pend = -1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    32'(MIDI_BUSY), 32'd0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
    check({tag, "_vmsg"},    32'(VOICE_MSG), 32'd0);
    check({tag, "_vrdy"},    32'(VOICE_MSG_RDY), 32'd0);
    check({tag, "_drop"},    32'(DROP), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue or overrun.
  always @(negedge CLK) begin
    if (mon_en) begin
      while (sq.size() > 0 && sq[0].due < cyc) begin
        me = sq.pop_front();
        check("issue_missing", 32'(cyc), 32'(me.due));
      end
      if (VOICE_MSG_RDY != '0 || DROP) begin
        if (sq.size() == 0) check("issue_unexpected", 32'({VOICE_MSG_RDY, DROP}), 32'd0);
        else begin
          me = sq.pop_front();
          check("issue_cycle", 32'(cyc), 32'(me.due));
          check("voice_rdy", 32'(VOICE_MSG_RDY), 32'(me.rdy));
          check("drop", 32'(DROP), 32'(me.drop));
          check("voice_msg", 32'(VOICE_MSG), 32'(me.msg));
        end
      end
      while (oq.size() > 0 && oq[0] < cyc) begin
        mo = oq.pop_front();
        check("overrun_missing", 32'(cyc), 32'(mo));
      end
      if (OVERRUN) begin
        if (oq.size() == 0) check("overrun_unexpected", 32'(OVERRUN), 32'd0);
        else begin
          mo = oq.pop_front();
          check("overrun_cycle", 32'(cyc), 32'(mo));
        end
      end
      check("busy", 32'(MIDI_BUSY), 32'(cyc >= bstart && cyc <= bend));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin own[i] = 1'b0; onote[i] = '0; act[i] = 1'b0; end
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    // first note to voice 0, then fill every voice and overflow into a drop
    for (int k = 0; k < 5; k++) begin
      send({8'h90, 8'h3C + 8'(k), 8'h64});
      wait_idle();
    end

    // note-off by 0x80 and by zero-velocity note-on; unmatched note-off is silent
    send(24'hB07B00); wait_idle();
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    send(24'h903C64); wait_idle();
    send(24'h903E64); wait_idle();
    send(24'h803E00); wait_idle();
    send(24'h903C00); wait_idle();
    send(24'h805000); wait_idle();

    // released but still sounding voices are skipped
    act[1] = 1'b0;
    send(24'h904140); wait_idle();
    act[0] = 1'b0;
    send(24'h904240); wait_idle();

    // ignored program change, then broadcast all-off
    send(24'hC00500); wait_idle();
    send(24'hB07B00); wait_idle();

    // overrun during scan, then reset mid-scan cancels the pending issue
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    send(24'h904564);
    @(posedge CLK); #1;
    inject();
    RST = 1'b1;
    sq.delete();
    bend = cyc;
    for (int i = 0; i < N; i++) begin own[i] = 1'b0; onote[i] = '0; end
    last = N - 1;
    pend = -1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_zero("midreset");
    repeat (LAT + 2) begin @(posedge CLK); #1; end

    // randomized traffic with random voice activity and overrun injection
    for (int t = 0; t < 300; t++) begin
      for (int v = 0; v < N; v++) begin
        if (act[v] && !own[v] && $urandom_range(0, 2) == 0) act[v] = 1'b0;
        else if (!act[v] && $urandom_range(0, 15) == 0) act[v] = 1'b1;
      end
      send(rand_msg());
      if (cyc <= bend && $urandom_range(0, 2) == 0) begin
        repeat (int'($urandom_range(0, 32'(bend - cyc)))) begin @(posedge CLK); #1; end
        inject();
      end
      wait_idle();
    end

    repeat (4) begin @(posedge CLK); #1; end
    check("sb_leftover", 32'(sq.size()), 32'd0);
    check("ovr_leftover", 32'(oq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
